// File: rtl/dual_path_checker.sv
// rtl/dual_path_checker.sv - compares blocking/non-blocking register-pair outputs over a sample window
// Optional mismatch history FIFO is enabled by defining DPC_HISTORY_EN.
module dual_path_checker #(
    parameter int W      = 4,
    parameter int WARMUP = 2,
    parameter int NSAMP  = 5,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [W-1:0]         b1,
    input  logic [W-1:0]         c1,
    input  logic [W-1:0]         b2,
    input  logic [W-1:0]         c2,
`ifdef DPC_HISTORY_EN
    input  logic                 hist_rd,
    output logic                 hist_valid,
    output logic [10+4*W-1:0]    hist_data,
    output logic                 hist_ovf,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_b,
    output logic [CNT_W-1:0]     err_c,
    output logic                 first_valid,
    output logic [7:0]           first_idx,
    output logic [1:0]           first_mask
);

    localparam int WC_W = $clog2(WARMUP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_CHECK, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] warm_cnt;
    logic [7:0]      idx_q;
    logic            b_mis, c_mis, any_mis, sample, restart;

    assign b_mis   = (b1 != b2);
    assign c_mis   = (c1 != c2);
    assign any_mis = b_mis | c_mis;
    assign sample  = (state_q == S_CHECK) && !abort;
    assign restart = !abort && start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WARM;
            S_WARM:         if (warm_cnt == WC_W'(1)) state_d = S_CHECK;
            S_CHECK:        if (idx_q == 8'(NSAMP - 1)) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Results survive abort; only a new start or reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            warm_cnt    <= '0;
            idx_q       <= '0;
            err_b       <= '0;
            err_c       <= '0;
            first_valid <= 1'b0;
            first_idx   <= '0;
            first_mask  <= '0;
        end else begin
            state_q <= state_d;
            if (restart) begin
                warm_cnt    <= WC_W'(WARMUP);
                idx_q       <= '0;
                err_b       <= '0;
                err_c       <= '0;
                first_valid <= 1'b0;
                first_idx   <= '0;
                first_mask  <= '0;
            end else if (!abort && state_q == S_WARM) begin
                warm_cnt <= warm_cnt - WC_W'(1);
                idx_q    <= '0;
            end else if (sample) begin
                if (b_mis && err_b != CNT_MAX) err_b <= err_b + CNT_W'(1);
                if (c_mis && err_c != CNT_MAX) err_c <= err_c + CNT_W'(1);
                if (any_mis && !first_valid) begin
                    first_valid <= 1'b1;
                    first_idx   <= idx_q;
                    first_mask  <= {c_mis, b_mis};
                end
                idx_q <= idx_q + 8'd1;
            end
        end
    end

    assign busy = (state_q == S_WARM) || (state_q == S_CHECK);
    assign done = (state_q == S_DONE);
    assign pass = done && (err_b == '0) && (err_c == '0);

`ifdef DPC_HISTORY_EN
    logic [10+4*W-1:0] mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        fcnt;
    logic              push, pop, full, wr_en;

    assign push  = sample && any_mis;
    assign full  = (fcnt == 3'd4);
    assign pop   = hist_rd && hist_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcnt     <= '0;
            hist_ovf <= 1'b0;
        end else if (restart) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcnt     <= '0;
            hist_ovf <= 1'b0;
        end else begin
            if (push && !wr_en) hist_ovf <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fcnt <= fcnt + {2'b00, wr_en} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {idx_q, c_mis, b_mis, b1, c1, b2, c2};
    end

    assign hist_valid = (fcnt != 3'd0);
    assign hist_data  = hist_valid ? mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_dual_path_checker.sv
// tb/tb_dual_path_checker.sv - table-driven bench for dual_path_checker
module tb_dual_path_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic [3:0] b1 = '0, c1 = '0, b2 = '0, c2 = '0;
    logic busy, done, pass, first_valid;
    logic [7:0] err_b, err_c, first_idx;
    logic [1:0] first_mask;

    logic start_s = 1'b0;
    logic busy_s, done_s, pass_s, first_valid_s;
    logic [3:0] err_b_s, err_c_s;
    logic [7:0] first_idx_s;
    logic [1:0] first_mask_s;

`ifdef DPC_HISTORY_EN
    logic hist_rd = 1'b0, hist_valid, hist_ovf;
    logic [25:0] hist_data;
    logic hist_rd_s = 1'b0, hist_valid_s, hist_ovf_s;
    logic [25:0] hist_data_s;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_path_checker #(.W(4), .WARMUP(2), .NSAMP(5), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .b1(b1), .c1(c1), .b2(b2), .c2(c2),
`ifdef DPC_HISTORY_EN
        .hist_rd(hist_rd), .hist_valid(hist_valid), .hist_data(hist_data), .hist_ovf(hist_ovf),
`endif
        .busy(busy), .done(done), .pass(pass), .err_b(err_b), .err_c(err_c),
        .first_valid(first_valid), .first_idx(first_idx), .first_mask(first_mask)
    );

    dual_path_checker #(.W(4), .WARMUP(2), .NSAMP(255), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0),
        .b1(4'h0), .c1(4'h0), .b2(4'hF), .c2(4'h5),
`ifdef DPC_HISTORY_EN
        .hist_rd(hist_rd_s), .hist_valid(hist_valid_s), .hist_data(hist_data_s), .hist_ovf(hist_ovf_s),
`endif
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_b(err_b_s), .err_c(err_c_s),
        .first_valid(first_valid_s), .first_idx(first_idx_s), .first_mask(first_mask_s)
    );

    typedef struct {
        logic [19:0] b1, b2, c1, c2;   // sample k in bits [4k+3:4k]
        logic [7:0]  eb, ec;
        logic        fv;
        logic [7:0]  fi;
        logic [1:0]  fm;
        logic        ps;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input vec_t v);
        b1 = v.b1[4*k +: 4];
        b2 = v.b2[4*k +: 4];
        c1 = v.c1[4*k +: 4];
        c2 = v.c2[4*k +: 4];
    endtask

    initial begin
        vecs[0] = '{20'h2AF73, 20'h2AF73, 20'h2AF73, 20'h2AF73, 8'd0, 8'd0, 1'b0, 8'd0, 2'b00, 1'b1};
        vecs[1] = '{20'h2AF73, 20'h2AF73, 20'h2AF73, 20'hAF730, 8'd0, 8'd5, 1'b1, 8'd0, 2'b10, 1'b0};
        vecs[2] = '{20'h2AF73, 20'h25F73, 20'h2AF73, 20'h2AF73, 8'd1, 8'd0, 1'b1, 8'd3, 2'b01, 1'b0};
        vecs[3] = '{20'h00000, 20'h10010, 20'h00000, 20'h00010, 8'd2, 8'd1, 1'b1, 8'd1, 2'b11, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_err", {err_b, err_c}, 0);
        check("reset_first", {first_valid, first_idx, first_mask}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("v%0d_busy_start", i), busy, 1);
            repeat (2) @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                drive(k, vecs[i]);
                @(negedge clk);
                check($sformatf("v%0d_done_k%0d", i, k), done, (k == 4));
            end
            check($sformatf("v%0d_err_b", i), err_b, vecs[i].eb);
            check($sformatf("v%0d_err_c", i), err_c, vecs[i].ec);
            check($sformatf("v%0d_first_valid", i), first_valid, vecs[i].fv);
            if (vecs[i].fv) begin
                check($sformatf("v%0d_first_idx", i), first_idx, vecs[i].fi);
                check($sformatf("v%0d_first_mask", i), first_mask, vecs[i].fm);
            end
            check($sformatf("v%0d_pass", i), pass, vecs[i].ps);
            check($sformatf("v%0d_busy_end", i), busy, 0);
            @(negedge clk);
        end

        // abort during warm-up keeps previous results, done stays low
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err_b_kept", err_b, 0);
        repeat (8) @(negedge clk);
        check("abort_done_stays0", done, 0);

        // start during CHECK must not restart the run
        b1 = 4'h0; b2 = 4'h0; c1 = 4'h0; c2 = 4'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 4) start = 1'b1;
            if (j == 5) start = 1'b0;
            if (j == 6) check("ignore_start_done6", done, 0);
            if (j == 7) check("ignore_start_done7", done, 1);
        end
        check("ignore_start_pass", pass, 1);

        // asynchronous reset in the middle of CHECK
        b2 = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("prereset_err_b", err_b, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy_done_pass", {busy, done, pass}, 0);
        check("midreset_err", {err_b, err_c}, 0);
        check("midreset_first", {first_valid, first_idx, first_mask}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        b2 = 4'h0;
        repeat (3) @(negedge clk);
        check("postreset_idle", {busy, done}, 0);

        // saturation on the long-window instance
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int t = 0; t < 400 && !done_s; t++) @(negedge clk);
        check("sat_done", done_s, 1);
        check("sat_err_b", err_b_s, 15);
        check("sat_err_c", err_c_s, 15);
        check("sat_first", {first_valid_s, first_idx_s, first_mask_s}, {1'b1, 8'd0, 2'b11});
        check("sat_pass", pass_s, 0);

`ifdef DPC_HISTORY_EN
        check("hist_ovf", hist_ovf_s, 1);
        for (int e = 0; e < 4; e++) begin
            check($sformatf("hist_valid_%0d", e), hist_valid_s, 1);
            check($sformatf("hist_idx_%0d", e), hist_data_s[25:18], e);
            check($sformatf("hist_mask_%0d", e), hist_data_s[17:16], 2'b11);
            hist_rd_s = 1'b1;
            @(negedge clk);
            hist_rd_s = 1'b0;
        end
        check("hist_empty", hist_valid_s, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
